// File: rtl/id_ex_stage.sv
// id_ex_stage: decode-to-execute pipeline register in front of the ALU.
// It holds one decoded instruction under a valid/ready handshake and
// presents ALU operands with EX-stage hazards resolved.
// A load-use hazard always stalls decode for one cycle.
// Optional feature macro: ID_EX_FORWARD_EN.
//   Defined:   MEM/WB results bypass into the operands.
//   Undefined: no bypass; decode waits until the register file holds the value.
module id_ex_stage #(
    parameter int XLEN = 32,
    parameter int RW   = 5
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            id_valid,
    output logic            id_ready,
    input  logic [XLEN-1:0] id_pc,
    input  logic [XLEN-1:0] id_imm,
    input  logic [XLEN-1:0] id_rf_rd0,
    input  logic [XLEN-1:0] id_rf_rd1,
    input  logic [RW-1:0]   id_rs0,
    input  logic [RW-1:0]   id_rs1,
    input  logic [RW-1:0]   id_rd,
    input  logic            id_rf_we,
    input  logic            id_is_load,
    input  logic            id_src0_sel,
    input  logic            id_src1_sel,
    input  logic [4:0]      id_alu_op,
    input  logic            flush,
    input  logic [RW-1:0]   mem_rd,
    input  logic [RW-1:0]   wb_rd,
    input  logic            mem_rf_we,
    input  logic            wb_rf_we,
    input  logic [XLEN-1:0] mem_wdata,
    input  logic [XLEN-1:0] wb_wdata,
    output logic            ex_valid,
    input  logic            ex_ready,
    output logic [XLEN-1:0] alu_src0,
    output logic [XLEN-1:0] alu_src1,
    output logic [4:0]      alu_op,
    output logic [XLEN-1:0] ex_pc,
    output logic [XLEN-1:0] ex_store_data,
    output logic [RW-1:0]   ex_rd,
    output logic            ex_rf_we,
    output logic            ex_is_load
);

`ifdef ID_EX_FORWARD_EN
    localparam logic FWD_EN = 1'b1;
`else
    localparam logic FWD_EN = 1'b0;
`endif

    logic            valid_q,    valid_d;
    logic [XLEN-1:0] pc_q,       pc_d;
    logic [XLEN-1:0] imm_q,      imm_d;
    logic [XLEN-1:0] rs0v_q,     rs0v_d;
    logic [XLEN-1:0] rs1v_q,     rs1v_d;
    logic [RW-1:0]   rs0_q,      rs0_d;
    logic [RW-1:0]   rs1_q,      rs1_d;
    logic [RW-1:0]   rd_q,       rd_d;
    logic            rf_we_q,    rf_we_d;
    logic            is_load_q,  is_load_d;
    logic            src0_sel_q, src0_sel_d;
    logic            src1_sel_q, src1_sel_d;
    logic [4:0]      alu_op_q,   alu_op_d;

    logic [XLEN-1:0] fwd0_s;
    logic [XLEN-1:0] fwd1_s;
    logic            load_use_s;
    logic            raw_s;
    logic            hazard_s;
    logic            fire_in_s;

    // Bypass: x0 reads as zero; MEM result beats WB result; else the held value.
    function automatic logic [XLEN-1:0] fwd(input logic [RW-1:0] idx,
                                            input logic [XLEN-1:0] val);
        logic [XLEN-1:0] res;
        if (idx == '0) begin
            res = '0;
        end else if (FWD_EN && mem_rf_we && (mem_rd == idx)) begin
            res = mem_wdata;
        end else if (FWD_EN && wb_rf_we && (wb_rd == idx)) begin
            res = wb_wdata;
        end else begin
            res = val;
        end
        return res;
    endfunction

    // A non-zero register that some later stage (EX, MEM or WB) is about to write.
    function automatic logic pending_write(input logic [RW-1:0] idx);
        return (idx != '0) &&
               ((valid_q && rf_we_q && (rd_q == idx)) ||
                (mem_rf_we && (mem_rd == idx)) ||
                (wb_rf_we && (wb_rd == idx)));
    endfunction

    // Forwarded operand values of the held instruction.
    always_comb begin
        fwd0_s = fwd(rs0_q, rs0v_q);
        fwd1_s = fwd(rs1_q, rs1v_q);
    end

    // Hazard detection and decode-side handshake.
    always_comb begin
        load_use_s = id_valid & valid_q & is_load_q & (rd_q != '0) &
                     ((rd_q == id_rs0) | (rd_q == id_rs1));
        if (FWD_EN) begin
            raw_s = 1'b0;
        end else begin
            raw_s = id_valid & (pending_write(id_rs0) | pending_write(id_rs1));
        end
        hazard_s  = load_use_s | raw_s;
        id_ready  = (~valid_q | ex_ready) & ~hazard_s;
        fire_in_s = id_valid & id_ready;
    end

    // Next-state selection: flush, then capture, then drain, then stall refresh.
    always_comb begin
        valid_d    = valid_q;
        pc_d       = pc_q;
        imm_d      = imm_q;
        rs0v_d     = rs0v_q;
        rs1v_d     = rs1v_q;
        rs0_d      = rs0_q;
        rs1_d      = rs1_q;
        rd_d       = rd_q;
        rf_we_d    = rf_we_q;
        is_load_d  = is_load_q;
        src0_sel_d = src0_sel_q;
        src1_sel_d = src1_sel_q;
        alu_op_d   = alu_op_q;
        if (flush) begin
            valid_d = 1'b0;
        end else if (fire_in_s) begin
            valid_d    = 1'b1;
            pc_d       = id_pc;
            imm_d      = id_imm;
            rs0v_d     = id_rf_rd0;
            rs1v_d     = id_rf_rd1;
            rs0_d      = id_rs0;
            rs1_d      = id_rs1;
            rd_d       = id_rd;
            rf_we_d    = id_rf_we;
            is_load_d  = id_is_load;
            src0_sel_d = id_src0_sel;
            src1_sel_d = id_src1_sel;
            alu_op_d   = id_alu_op;
        end else if (ex_ready) begin
            valid_d = 1'b0;
        end else if (valid_q) begin
            // Stalled: latch bypassed values so a producer retiring now is kept.
            rs0v_d = fwd0_s;
            rs1v_d = fwd1_s;
        end else begin
            valid_d = valid_q;
        end
    end

    // Holding register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            valid_q    <= 1'b0;
            pc_q       <= '0;
            imm_q      <= '0;
            rs0v_q     <= '0;
            rs1v_q     <= '0;
            rs0_q      <= '0;
            rs1_q      <= '0;
            rd_q       <= '0;
            rf_we_q    <= 1'b0;
            is_load_q  <= 1'b0;
            src0_sel_q <= 1'b0;
            src1_sel_q <= 1'b0;
            alu_op_q   <= 5'b00000;
        end else begin
            valid_q    <= valid_d;
            pc_q       <= pc_d;
            imm_q      <= imm_d;
            rs0v_q     <= rs0v_d;
            rs1v_q     <= rs1v_d;
            rs0_q      <= rs0_d;
            rs1_q      <= rs1_d;
            rd_q       <= rd_d;
            rf_we_q    <= rf_we_d;
            is_load_q  <= is_load_d;
            src0_sel_q <= src0_sel_d;
            src1_sel_q <= src1_sel_d;
            alu_op_q   <= alu_op_d;
        end
    end

    assign ex_valid      = valid_q;
    assign alu_src0      = src0_sel_q ? pc_q : fwd0_s;
    assign alu_src1      = src1_sel_q ? imm_q : fwd1_s;
    assign ex_store_data = fwd1_s;
    assign alu_op        = alu_op_q;
    assign ex_pc         = pc_q;
    assign ex_rd         = rd_q;
    assign ex_rf_we      = rf_we_q;
    assign ex_is_load    = is_load_q;

endmodule
